multi_operand_compressor: RTL and testbench

Parametrised, pipelined N:3 bitwise column compressor with valid tracking and clock-enable stall. It generalises our fixed 6:3 compressor to any operand count from 3 to 7. Each bit column of the N_IN input vectors is reduced to a 3-bit population count, so the datapath presents three vectors X, Y, Z with weights 1, 2, 4. It sits in front of the DSP-block adder chain of the spatial filter. The downstream adder forms X + (Y<<1) + (Z<<2).

---
 rtl/mcomp_pkg.sv | 27 ++
 rtl/column_popcount.sv | 19 +
 rtl/multi_operand_compressor.sv | 111 +++++++++++
 tb/tb_multi_operand_compressor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcomp_pkg.sv
// Shared constants and elaboration helpers for the N:3 column compressor.
package mcomp_pkg;

  // Width of a per-column population count (holds 0..7).
  localparam int unsigned CNT_W    = 3;
  // Largest operand count whose column sum still fits in CNT_W bits.
  localparam int unsigned MAX_N_IN = 7;

  // Number of bits needed to represent the value n (clog2(n+1)).
  function automatic int unsigned cnt_bits(input int unsigned n);
    int unsigned b;
    int unsigned v;
    b = 0;
    v = n;
    while (v != 0) begin
      b++;
      v = v >> 1;
    end
    return b;
  endfunction

  // True when an N-operand column count fits the 3-bit X/Y/Z encoding.
  function automatic bit n_in_legal(input int unsigned n);
    return (n >= 3) && (n <= MAX_N_IN) && (cnt_bits(n) <= CNT_W);
  endfunction

endpackage

// File: rtl/column_popcount.sv
// Combinational population count of one bit column across all operands.
module column_popcount
  import mcomp_pkg::*;
#(
  parameter int unsigned N_IN = 6
) (
  input  logic [N_IN-1:0]  bits,
  output logic [CNT_W-1:0] cnt
);

  // Sum the column bits; N_IN <= 7 keeps the result within CNT_W bits.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < N_IN; k++) begin
      cnt = cnt + CNT_W'(bits[k]);
    end
  end

endmodule

// File: rtl/multi_operand_compressor.sv
// Pipelined N:3 bitwise column compressor. Each column of the N_IN operands is
// reduced to a 3-bit count presented as X (weight 1), Y (weight 2), Z (weight 4).
// Every register, valids included, advances only when ce is high.
module multi_operand_compressor
  import mcomp_pkg::*;
#(
  parameter int unsigned WIDTH  = 45,
  parameter int unsigned N_IN   = 6,
  parameter int unsigned X_SKEW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]      X,
  output logic [WIDTH-1:0]      Y,
  output logic [WIDTH-1:0]      Z,
  output logic                  yz_valid,
  output logic                  x_valid
);

  // Reject operand counts whose column sum would not fit the X/Y/Z encoding.
  if (!n_in_legal(N_IN)) begin : gen_bad_n_in
    $fatal(1, "multi_operand_compressor: N_IN must be in 3..%0d", MAX_N_IN);
  end
  if (X_SKEW > 1) begin : gen_bad_x_skew
    $fatal(1, "multi_operand_compressor: X_SKEW must be 0 or 1");
  end

  logic [N_IN*WIDTH-1:0] in_q;
  logic                  v0_q;
  logic                  v1_q;
  logic [WIDTH-1:0]      x_d, y_d, z_d;
  logic [WIDTH-1:0]      x_q, y_q, z_q;

  // Stage 0: capture operands, or zeros on idle cycles so idle yields zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      v0_q <= 1'b0;
    end else if (ce) begin
      in_q <= in_valid ? in_data : '0;
      v0_q <= in_valid;
    end
  end

  // One popcount per bit column; the count bits scatter into X/Y/Z.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_col
    logic [N_IN-1:0]  col;
    logic [CNT_W-1:0] cnt;

    for (genvar k = 0; k < N_IN; k++) begin : gen_bit
      assign col[k] = in_q[k*WIDTH + i];
    end

    column_popcount #(
      .N_IN (N_IN)
    ) u_popcount (
      .bits (col),
      .cnt  (cnt)
    );

    // For N_IN <= 3 cnt[2] is always zero, so Z is driven but constant.
    assign x_d[i] = cnt[0];
    assign y_d[i] = cnt[1];
    assign z_d[i] = cnt[2];
  end

  // Stage 1: register the three weight vectors and advance the valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      v1_q <= 1'b0;
    end else if (ce) begin
      x_q  <= x_d;
      y_q  <= y_d;
      z_q  <= z_d;
      v1_q <= v0_q;
    end
  end

  assign Y        = y_q;
  assign Z        = z_q;
  assign yz_valid = v1_q;

  if (X_SKEW == 1) begin : gen_x_skew
    logic [WIDTH-1:0] xs_q;
    logic             xv_q;

    // Extra X stage so X lines up with the next DSP in the cascade.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        xs_q <= '0;
        xv_q <= 1'b0;
      end else if (ce) begin
        xs_q <= x_q;
        xv_q <= v1_q;
      end
    end

    assign X       = xs_q;
    assign x_valid = xv_q;
  end else begin : gen_no_skew
    assign X       = x_q;
    assign x_valid = v1_q;
  end

endmodule

// File: tb/tb_multi_operand_compressor.sv
// Directed bench for multi_operand_compressor: a 6-operand skewed instance and a
// 7-operand unskewed instance share clock, reset, ce and in_valid.
module tb_multi_operand_compressor;

  localparam int unsigned W  = 8;
  localparam int unsigned NV = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce = 1'b0;
  logic           in_valid = 1'b0;
  logic [6*W-1:0] d6 = '0;
  logic [7*W-1:0] d7 = '0;
  logic [W-1:0]   x6, y6, z6, x7, y7, z7;
  logic           xv6, yzv6, xv7, yzv7;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0][7:0] ops;
    logic [7:0]      x6, y6, z6, x7, y7, z7;
  } vec_t;

  vec_t vecs [NV];

  multi_operand_compressor #(
    .WIDTH  (W),
    .N_IN   (6),
    .X_SKEW (1)
  ) dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_data  (d6),
    .X        (x6),
    .Y        (y6),
    .Z        (z6),
    .yz_valid (yzv6),
    .x_valid  (xv6)
  );

  multi_operand_compressor #(
    .WIDTH  (W),
    .N_IN   (7),
    .X_SKEW (0)
  ) dut7 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_data  (d7),
    .X        (x7),
    .Y        (y7),
    .Z        (z7),
    .yz_valid (yzv7),
    .x_valid  (xv7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0][7:0] ops);
    in_valid = v;
    d7       = ops;
    d6       = ops[5:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x6"}, x6, 0);
    chk({tag, "_y6"}, y6, 0);
    chk({tag, "_z6"}, z6, 0);
    chk({tag, "_xv6"}, xv6, 0);
    chk({tag, "_yzv6"}, yzv6, 0);
    chk({tag, "_x7"}, x7, 0);
    chk({tag, "_y7"}, y7, 0);
    chk({tag, "_z7"}, z7, 0);
    chk({tag, "_xv7"}, xv7, 0);
    chk({tag, "_yzv7"}, yzv7, 0);
  endtask

  task automatic chk_dut7(input string tag, input vec_t e);
    chk({tag, "_x7"}, x7, e.x7);
    chk({tag, "_y7"}, y7, e.y7);
    chk({tag, "_z7"}, z7, e.z7);
    chk({tag, "_xv7"}, xv7, 1);
    chk({tag, "_yzv7"}, yzv7, 1);
  endtask

  task automatic chk_dut6_yz(input string tag, input vec_t e);
    chk({tag, "_y6"}, y6, e.y6);
    chk({tag, "_z6"}, z6, e.z6);
    chk({tag, "_yzv6"}, yzv6, 1);
  endtask

  task automatic chk_dut6_x(input string tag, input vec_t e);
    chk({tag, "_x6"}, x6, e.x6);
    chk({tag, "_xv6"}, xv6, 1);
  endtask

  function automatic logic [6:0][7:0] rnd_ops();
    logic [6:0][7:0] r;
    for (int k = 0; k < 7; k++) r[k] = 8'($urandom);
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] o0, o1, o2, o3, o4, o5, o6,
                              input logic [7:0] ex6, ey6, ez6, ex7, ey7, ez7);
    vec_t r;
    r.ops[0] = o0; r.ops[1] = o1; r.ops[2] = o2; r.ops[3] = o3;
    r.ops[4] = o4; r.ops[5] = o5; r.ops[6] = o6;
    r.x6 = ex6; r.y6 = ey6; r.z6 = ez6;
    r.x7 = ex7; r.y7 = ey7; r.z7 = ez7;
    return r;
  endfunction

  initial begin
    int q6[$], q7[$], py[$], pz[$];
    logic [6:0][7:0] ops;
    logic v;
    int s6, s7;

    // Counts: 6 -> 110b, 7 -> 111b, 3 -> 011b, 4 -> 100b, 5 -> 101b, 2 -> 010b.
    vecs[0] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vecs[1] = mk(8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h07, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00);
    vecs[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF,
                 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    vecs[4] = mk(8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'hFF,
                 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    vecs[5] = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01,
                 8'h81, 8'h00, 8'h80, 8'h80, 8'h01, 8'h80);
    vecs[6] = mk(8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h00, 8'h55,
                 8'hAA, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);

    // Reset state, before and just after release.
    #2;
    chk_all_zero("rst");
    #20;
    rst_n = 1'b1;
    ce    = 1'b1;
    drive(1'b0, rnd_ops());
    step();
    chk_all_zero("post_rst");

    // Back-to-back table vectors followed by idle cycles with random data.
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) drive(1'b1, vecs[c].ops);
      else        drive(1'b0, rnd_ops());
      step();
      if (c >= 1 && c - 1 < NV) begin
        chk_dut7($sformatf("vec%0d", c - 1), vecs[c-1]);
        chk_dut6_yz($sformatf("vec%0d", c - 1), vecs[c-1]);
      end
      if (c >= 2) chk_dut6_x($sformatf("vec%0d", c - 2), vecs[c-2]);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, rnd_ops());
      step();
      chk_all_zero($sformatf("idle%0d", i));
    end

    // ce stall: A, B valid; then 3 stalled cycles presenting C (must be dropped).
    drive(1'b1, vecs[5].ops);
    step();
    drive(1'b1, vecs[6].ops);
    step();
    chk_dut7("stallA", vecs[5]);
    chk_dut6_yz("stallA", vecs[5]);
    chk("stallA_xv6", xv6, 0);
    ce = 1'b0;
    drive(1'b1, vecs[0].ops);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dut7($sformatf("hold%0d", i), vecs[5]);
      chk_dut6_yz($sformatf("hold%0d", i), vecs[5]);
      chk($sformatf("hold%0d_xv6", i), xv6, 0);
      chk($sformatf("hold%0d_x6", i), x6, 0);
    end
    ce = 1'b1;
    drive(1'b0, rnd_ops());
    step();
    chk_dut7("stallB", vecs[6]);
    chk_dut6_yz("stallB", vecs[6]);
    chk_dut6_x("stallA", vecs[5]);
    drive(1'b0, rnd_ops());
    step();
    chk("stall_end_yzv7", yzv7, 0);
    chk("stall_end_x7", x7, 0);
    chk("stall_end_yzv6", yzv6, 0);
    chk("stall_end_y6", y6, 0);
    chk_dut6_x("stallB", vecs[6]);
    step();
    chk("stall_end_xv6", xv6, 0);
    chk("stall_end_x6", x6, 0);

    // Asynchronous reset between edges with results in flight.
    drive(1'b1, vecs[1].ops);
    step();
    drive(1'b1, vecs[4].ops);
    step();
    chk("pre_rst_yzv7", yzv7, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    chk_all_zero("in_rst");
    drive(1'b0, rnd_ops());
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero($sformatf("no_stale%0d", i));
    end
    drive(1'b1, vecs[5].ops);
    step();
    drive(1'b0, rnd_ops());
    step();
    chk_dut7("after_rst", vecs[5]);
    chk_dut6_yz("after_rst", vecs[5]);
    step();
    chk_dut6_x("after_rst", vecs[5]);
    chk("after_rst_yzv7", yzv7, 0);

    // Random stream: X + 2Y + 4Z must equal the integer sum of the operands.
    for (int t = 0; t < 304; t++) begin
      ops = rnd_ops();
      v   = (t < 300) && ($urandom_range(0, 3) != 0);
      drive(v, ops);
      if (v) begin
        s6 = 0;
        s7 = 0;
        for (int k = 0; k < 7; k++) begin
          if (k < 6) s6 += int'(ops[k]);
          s7 += int'(ops[k]);
        end
        q6.push_back(s6);
        q7.push_back(s7);
      end
      step();
      if (yzv7) begin
        if (q7.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand7_extra valid with no pending transaction");
        end else begin
          chk("rand7_sum", int'(x7) + 2 * int'(y7) + 4 * int'(z7), q7.pop_front());
        end
      end
      if (yzv6) begin
        py.push_back(int'(y6));
        pz.push_back(int'(z6));
      end
      if (xv6) begin
        if (py.size() == 0 || q6.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand6_extra x_valid with no pending Y/Z or transaction");
        end else begin
          chk("rand6_sum", int'(x6) + 2 * py.pop_front() + 4 * pz.pop_front(),
              q6.pop_front());
        end
      end
    end
    chk("rand7_drain", q7.size(), 0);
    chk("rand6_drain", q6.size(), 0);
    chk("rand6_yz_drain", py.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
